// File: rtl/instr_sequencer.sv
// instr_sequencer: steps through a small program buffer, pulsing one instruction per slot to a datapath
module instr_sequencer #(
  parameter int DEPTH  = 16,
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [10:0] prog_data,
  input  logic [4:0]  prog_len,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  result_in,
  output logic [10:0] instruction,
  output logic        execute_next,
  output logic [3:0]  pc,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  result_out,
  output logic        result_valid
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [4:0]  len_q, len_d;
  logic [3:0]  pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [10:0] mem_q [DEPTH];
  logic [7:0]  result_q;
  logic        result_valid_q, error_q;
  logic        start_ok, start_bad, last_wait, at_last, capture;
  assign start_ok     = state_q == IDLE && start && prog_len != 5'd0 && prog_len <= 5'(DEPTH);
  assign start_bad    = state_q == IDLE && start && !start_ok;
  assign last_wait    = state_q == WAIT && cnt_q == 3'(SETTLE - 1);
  assign at_last      = {1'b0, pc_q} == len_q - 5'd1;
  assign capture      = last_wait && !abort && instruction[10:8] == 3'b111;
  assign busy         = state_q == ISSUE || state_q == WAIT;
  assign execute_next = state_q == ISSUE;
  assign done         = state_q == DONE;
  assign instruction  = busy ? mem_q[pc_q[AW-1:0]] : 11'd0;
  assign pc           = pc_q;
  assign error        = error_q;
  assign result_out   = result_q;
  assign result_valid = result_valid_q;
  // Program buffer: writable only while idle, survives reset
  always_ff @(posedge clk)
    if (prog_we && state_q == IDLE) mem_q[prog_addr[AW-1:0]] <= prog_data;
  // Next-state: start/issue/settle/complete sequencing with abort out of ISSUE and WAIT
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (start_ok) begin
      state_d = ISSUE;
      len_d   = prog_len;
      pc_d    = 4'd0;
    end else if (state_q == ISSUE) begin
      state_d = abort ? IDLE : WAIT;
      cnt_d   = 3'd0;
    end else if (state_q == WAIT) begin
      if (abort) state_d = IDLE;
      else if (last_wait) begin
        state_d = at_last ? DONE : ISSUE;
        pc_d    = at_last ? pc_q : pc_q + 4'd1;
      end else cnt_d = cnt_q + 3'd1;
    end else if (state_q == DONE) state_d = IDLE;
  end
  // State, counters and pulse/result registers
  always_ff @(posedge clk)
    if (reset) begin
      state_q        <= IDLE;
      len_q          <= 5'd0;
      pc_q           <= 4'd0;
      cnt_q          <= 3'd0;
      error_q        <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= 8'd0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      pc_q           <= pc_d;
      cnt_q          <= cnt_d;
      error_q        <= start_bad;
      result_valid_q <= capture;
      if (capture) result_q <= result_in;
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed scenarios for instr_sequencer with hand-computed expectations
module tb_instr_sequencer;
  logic        clk = 0, reset = 1, prog_we = 0, start = 0, abort = 0;
  logic [3:0]  prog_addr = 0;
  logic [10:0] prog_data = 0;
  logic [4:0]  prog_len = 0;
  logic [7:0]  result_in = 0;
  logic [10:0] instruction;
  logic        execute_next, busy, done, error, result_valid;
  logic [3:0]  pc;
  logic [7:0]  result_out;
  int vectors = 0, miscompares = 0;

  instr_sequencer #(.DEPTH(16), .SETTLE(2)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_len(prog_len), .start(start), .abort(abort), .result_in(result_in),
    .instruction(instruction), .execute_next(execute_next), .pc(pc), .busy(busy), .done(done),
    .error(error), .result_out(result_out), .result_valid(result_valid));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [10:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    tick(); tick();
    reset = 0;
    vectors++;
    if ({busy, done, error, execute_next, result_valid} !== 5'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b want 00000", {busy, done, error, execute_next, result_valid});
    end
    vectors++;
    if ({pc, result_out, instruction} !== 23'd0) begin
      miscompares++; $display("FAIL reset_regs: got pc=%h res=%h instr=%h want 0", pc, result_out, instruction);
    end
  endtask

  task automatic test_program;
    load(4'd0, 11'h005); load(4'd1, 11'h203); load(4'd2, 11'h700);
    result_in = 8'h05; prog_len = 5'd3; start = 1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      start = 0;
      vectors++;
      if (execute_next !== (k == 1 || k == 4 || k == 7)) begin
        miscompares++; $display("FAIL prog_exec k=%0d: got %b want %b", k, execute_next, (k == 1 || k == 4 || k == 7));
      end
      vectors++;
      if (done !== (k == 10) || result_valid !== (k == 10)) begin
        miscompares++; $display("FAIL prog_done k=%0d: got done=%b rv=%b want %b", k, done, result_valid, (k == 10));
      end
      vectors++;
      if (busy !== (k <= 9)) begin
        miscompares++; $display("FAIL prog_busy k=%0d: got %b want %b", k, busy, (k <= 9));
      end
      if (k == 1 || k == 4 || k == 7) begin
        vectors++;
        if (instruction !== (k == 1 ? 11'h005 : k == 4 ? 11'h203 : 11'h700)) begin
          miscompares++; $display("FAIL prog_instr k=%0d: got %h", k, instruction);
        end
      end
      if (k == 10) begin
        vectors++;
        if (result_out !== 8'h05 || pc !== 4'd2) begin
          miscompares++; $display("FAIL prog_result: got res=%h pc=%0d want 05 2", result_out, pc);
        end
      end
    end
  endtask

  task automatic test_error;
    for (int j = 0; j < 2; j++) begin
      prog_len = j == 0 ? 5'd0 : 5'd17; start = 1;
      tick();
      start = 0;
      vectors++;
      if (error !== 1'b1 || busy !== 1'b0) begin
        miscompares++; $display("FAIL error_pulse len=%0d: got err=%b busy=%b want 1 0", prog_len, error, busy);
      end
      tick();
      vectors++;
      if (error !== 1'b0 || busy !== 1'b0) begin
        miscompares++; $display("FAIL error_clear len=%0d: got err=%b busy=%b want 0 0", prog_len, error, busy);
      end
    end
  endtask

  task automatic test_abort;
    int extra = 0;
    result_in = 8'h11; prog_len = 5'd3; start = 1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      start = 0;
    end
    abort = 1;
    tick();
    abort = 0;
    vectors++;
    if (busy !== 1'b0 || execute_next !== 1'b0 || done !== 1'b0 || pc !== 4'd1) begin
      miscompares++; $display("FAIL abort_state: got busy=%b ex=%b done=%b pc=%0d want 0 0 0 1", busy, execute_next, done, pc);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done || execute_next || result_valid) extra++;
    end
    vectors++;
    if (extra !== 0 || result_out !== 8'h05) begin
      miscompares++; $display("FAIL abort_quiet: got pulses=%0d res=%h want 0 05", extra, result_out);
    end
  endtask

  task automatic test_reset_mid;
    int extra = 0;
    prog_len = 5'd3; start = 1;
    tick();
    start = 0;
    vectors++;
    if (execute_next !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_issue: got %b want 1", execute_next);
    end
    reset = 1;
    tick();
    reset = 0;
    vectors++;
    if ({busy, done, error, execute_next, result_valid, pc, result_out, instruction} !== 28'd0) begin
      miscompares++; $display("FAIL rstmid_outputs: got busy=%b ex=%b pc=%0d res=%h instr=%h want 0", busy, execute_next, pc, result_out, instruction);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      if (execute_next || busy) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      miscompares++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_write_busy;
    prog_len = 5'd1; start = 1;
    tick();
    start = 0;
    prog_we = 1; prog_addr = 4'd0; prog_data = 11'h7AA;
    tick();
    prog_we = 0;
    tick(); tick(); tick();
    start = 1;
    tick();
    start = 0;
    vectors++;
    if (instruction !== 11'h005 || execute_next !== 1'b1) begin
      miscompares++; $display("FAIL busy_write: got instr=%h ex=%b want 005 1", instruction, execute_next);
    end
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_write_and_start;
    prog_we = 1; prog_addr = 4'd0; prog_data = 11'h712; result_in = 8'h33; prog_len = 5'd1; start = 1;
    tick();
    prog_we = 0; start = 0;
    vectors++;
    if (instruction !== 11'h712 || execute_next !== 1'b1) begin
      miscompares++; $display("FAIL write_start: got instr=%h ex=%b want 712 1", instruction, execute_next);
    end
    tick(); tick(); tick();
    vectors++;
    if (done !== 1'b1 || result_valid !== 1'b1 || result_out !== 8'h33) begin
      miscompares++; $display("FAIL write_start_result: got done=%b rv=%b res=%h want 1 1 33", done, result_valid, result_out);
    end
    tick();
  endtask

  task automatic test_len16;
    int exec_cnt = 0, done_cnt = 0;
    logic [10:0] exp_i;
    for (int i = 0; i < 16; i++) load(4'(i), 11'h100 + 11'(i));
    prog_len = 5'd16; start = 1;
    for (int k = 1; k <= 55; k++) begin
      tick();
      start = 0;
      if (execute_next) begin
        exp_i = 11'h100 + 11'(exec_cnt);
        vectors++;
        if (pc !== 4'(exec_cnt) || instruction !== exp_i) begin
          miscompares++; $display("FAIL len16_issue k=%0d: got pc=%0d instr=%h want %0d %h", k, pc, instruction, exec_cnt, exp_i);
        end
        exec_cnt++;
      end
      if (done) begin
        done_cnt++;
        vectors++;
        if (k !== 49) begin
          miscompares++; $display("FAIL len16_done_time: got cycle %0d want 49", k);
        end
      end
    end
    vectors++;
    if (exec_cnt !== 16 || done_cnt !== 1 || pc !== 4'd15) begin
      miscompares++; $display("FAIL len16_totals: got exec=%0d done=%0d pc=%0d want 16 1 15", exec_cnt, done_cnt, pc);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_error();
    test_abort();
    test_reset_mid();
    test_write_busy();
    test_write_and_start();
    test_len16();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16; program buffer entries, power of two, 2..16.
REQ-002 SHALL have parameter SETTLE, default 2; idle cycles after each issue pulse, 1..7.
REQ-003 SHALL have port clk  input  1  clock; all logic is rising-edge.
REQ-004 SHALL have port reset  input  1  reset; reset is synchronous and active-high.
REQ-005 SHALL have port prog_we  input  1  program buffer write strobe.
REQ-006 SHALL have port prog_addr  input  4  program buffer write address; only the low log2(DEPTH) bits are used.
REQ-007 SHALL have port prog_data  input  11  instruction word to write: [10:8] opcode, [7:0] operand.
REQ-008 SHALL have port prog_len  input  5  program length, sampled on start.
REQ-009 SHALL have port start  input  1  begin program execution.
REQ-010 SHALL have port abort  input  1  stop execution.
REQ-011 SHALL have port result_in  input  8  result value returned by the datapath.
REQ-012 SHALL have port instruction  output  11  instruction word presented to the datapath.
REQ-013 SHALL have port execute_next  output  1  one-cycle load strobe to the datapath.
REQ-014 SHALL have port pc  output  4  index of the current instruction.
REQ-015 SHALL have port busy  output  1  high in ISSUE and WAIT.
REQ-016 SHALL have port done  output  1  one-cycle completion pulse.
REQ-017 SHALL have port error  output  1  one-cycle pulse on a rejected start.
REQ-018 SHALL have port result_out  output  8  captured result.
REQ-019 SHALL have port result_valid  output  1  one-cycle pulse when result_out updates.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT and DONE, plus a registered length, a pc counter and a settle counter.
REQ-021 SHALL write prog_data to mem[prog_addr] on a prog_we edge only in IDLE; writes in any other state are ignored.
REQ-022 SHALL, on start in IDLE with prog_len in 1..DEPTH, latch prog_len, clear pc and enter ISSUE on the next edge.
REQ-023 SHALL, on start in IDLE with prog_len 0 or prog_len > DEPTH, pulse error for one cycle and remain in IDLE.
REQ-024 SHALL ignore start outside IDLE.
REQ-025 SHALL, in ISSUE, drive instruction = mem[pc] and execute_next = 1 for exactly one cycle, then enter WAIT with the settle counter at 0.
REQ-026 SHALL, in WAIT, hold instruction stable with execute_next = 0 for SETTLE cycles.
REQ-027 SHALL, in the last WAIT cycle, when instruction[10:8] = 3'b111, register result_in into result_out and pulse result_valid on the following cycle.
REQ-028 SHALL, after the last WAIT cycle, go to DONE when pc = len-1; otherwise increment pc and go to ISSUE.
REQ-029 SHALL give each instruction a cost of exactly 1+SETTLE cycles; a program of N instructions raises done 1+N*(1+SETTLE) cycles after the start edge.
REQ-030 SHALL hold done = 1 for one cycle in DONE, then return to IDLE; pc holds its last value.
REQ-031 SHALL, on abort in ISSUE or WAIT, go to IDLE on the next edge with execute_next = 0 and no done or result_valid pulse.
REQ-032 SHALL give abort priority over start, and ignore abort in IDLE and DONE.
REQ-033 SHALL, when start and prog_we occur in the same IDLE cycle, perform the write and also accept the start; the first ISSUE reads the updated buffer.
REQ-034 SHALL never increment pc beyond len-1, so pc does not wrap.

Reset
REQ-035 SHALL, on reset, enter IDLE and clear pc, busy, done, error, execute_next, result_valid, result_out, instruction and the latched length.
REQ-036 SHALL take reset priority over all inputs, including mid-program; buffer contents are not cleared.
REQ-037 SHALL, after a mid-program reset, produce no further execute_next pulse until a new start is accepted.

Verification
REQ-038 SHALL pass this scenario: load 0x005, 0x203, 0x700 at addresses 0..2, start with len=3 and SETTLE=2, result_in=8'h05 -> three execute_next pulses spaced 3 cycles apart, result_out=8'h05 with result_valid, done 10 cycles after the start edge.
REQ-039 SHALL pass this scenario: start with len=0, then with len=17 -> error pulses each time, busy stays 0.
REQ-040 SHALL pass this scenario: abort during the WAIT of the 2nd instruction -> IDLE next cycle, no done, pc=1.
REQ-041 SHALL pass this scenario: reset asserted during ISSUE -> all outputs 0 on the next cycle, execute_next stays 0 afterwards.
REQ-042 SHALL pass this scenario: prog_we during busy to address 0 -> a rerun issues the original mem[0].
REQ-043 SHALL pass this scenario: len=16 -> pc runs 0..15 without wrap and done fires once.
